// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage MIPS pipeline operand-forwarding logic.
//   DW, RW        : datapath and register-index widths
//   stage_t       : one tracked pipeline-stage entry {valid, we, dst, load}
//   sel_t         : bypass select encodings (regfile / EX / MEM / WB)
//   OP_LW, OP_LHU : opcodes of the load instructions whose data arrives after MEM
//   SYSCALL_WORD  : the full instruction word of a syscall
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int DW = 32;
    localparam int RW = 5;

    // The destination field is called dst because "reg" is a keyword.
    typedef struct packed {
        logic          valid;
        logic          we;
        logic [RW-1:0] dst;
        logic          load;
    } stage_t;

    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_EX  = 2'd1,
        SEL_MEM = 2'd2,
        SEL_WB  = 2'd3
    } sel_t;

    localparam logic [5:0]  OP_LW        = 6'b100011;
    localparam logic [5:0]  OP_LHU       = 6'b100101;
    localparam logic [31:0] SYSCALL_WORD = 32'd12;

    // Decoder helper: true for the opcodes whose result is only known after MEM.
    function automatic logic is_load_opcode(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LHU);
    endfunction

    // Decoder helper: true for the syscall instruction word.
    function automatic logic is_syscall(input logic [31:0] word);
        return word == SYSCALL_WORD;
    endfunction

    // An entry provides a register value only if it is live, writes, and the
    // register is not $0 (which is hard-wired to zero).
    function automatic logic entry_hits(input stage_t e, input logic [RW-1:0] r);
        return e.valid && e.we && (e.dst == r) && (r != '0);
    endfunction

endpackage

// File: rtl/bypass_match.sv
// -----------------------------------------------------------------------------
// bypass_match
// Combinational lookup of one decode-stage source register against the EX,
// MEM and WB entries, youngest first.
//   ex, mem, wb : tracked stage entries
//   rs          : source register being queried
//   sel         : where the operand should come from
//   load_use    : rs is produced by a load still in EX (data not yet ready)
// -----------------------------------------------------------------------------
module bypass_match
    import cpu_pkg::*;
(
    input  stage_t        ex,
    input  stage_t        mem,
    input  stage_t        wb,
    input  logic [RW-1:0] rs,
    output sel_t          sel,
    output logic          load_use
);

    // A load hit in EX must not fall through to an older stage: the older
    // value is stale, so the decode stage has to wait instead.
    always_comb begin
        sel      = SEL_RF;
        load_use = 1'b0;
        if (entry_hits(ex, rs)) begin
            if (ex.load) begin
                load_use = 1'b1;
            end else begin
                sel = SEL_EX;
            end
        end else if (entry_hits(mem, rs)) begin
            sel = SEL_MEM;
        end else if (entry_hits(wb, rs)) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/wb_bypass_tracker.sv
// -----------------------------------------------------------------------------
// wb_bypass_tracker
// Producer side of operand forwarding: tracks the destination of every
// instruction in EX, MEM and WB and answers the two decode-stage source
// queries with a bypass select, the bypassed data and a load-use stall.
//   in_CLK, in_RST       : clock, synchronous active-low reset
//   in_EN                : pipeline advance (0 holds all state)
//   in_FLUSH             : taken branch/jump, kills the instruction entering EX
//   in_DVALID/DWE/DREG/DLOAD : decoded instruction fields
//   in_EXRES/MEMRES/WBRES    : results currently held by EX, MEM, WB
//   in_RSA, in_RSB       : decode source registers
//   out_SELA/B, out_FWDA/B   : bypass select and data per query port
//   out_STALL            : load-use hazard, decode must hold
//   out_PEND             : number of live register-writing entries
// Optional macro SYSCALL_FWD_EN adds in_DSYS, out_SYSSEL and out_SYSSTALL for
// the implicit syscall operands $2 and $4.
// -----------------------------------------------------------------------------
module wb_bypass_tracker
    import cpu_pkg::*;
#(
    parameter int DW   = cpu_pkg::DW,
    parameter int RW   = cpu_pkg::RW,
    parameter int NSTG = 3
) (
    input  logic          in_CLK,
    input  logic          in_RST,
    input  logic          in_EN,
    input  logic          in_FLUSH,
    input  logic          in_DVALID,
    input  logic          in_DWE,
    input  logic [RW-1:0] in_DREG,
    input  logic          in_DLOAD,
    input  logic [DW-1:0] in_EXRES,
    input  logic [DW-1:0] in_MEMRES,
    input  logic [DW-1:0] in_WBRES,
    input  logic [RW-1:0] in_RSA,
    input  logic [RW-1:0] in_RSB,
`ifdef SYSCALL_FWD_EN
    input  logic          in_DSYS,
    output logic [3:0]    out_SYSSEL,
    output logic          out_SYSSTALL,
`endif
    output logic [1:0]    out_SELA,
    output logic [1:0]    out_SELB,
    output logic [DW-1:0] out_FWDA,
    output logic [DW-1:0] out_FWDB,
    output logic          out_STALL,
    output logic [1:0]    out_PEND
);

    // Index 0 = EX, 1 = MEM, 2 = WB.
    stage_t stg [NSTG];
    sel_t   sel_a;
    sel_t   sel_b;
    logic   lu_a;
    logic   lu_b;
    logic   load_use;

    bypass_match u_match_a (
        .ex       (stg[0]),
        .mem      (stg[1]),
        .wb       (stg[2]),
        .rs       (in_RSA),
        .sel      (sel_a),
        .load_use (lu_a)
    );

    bypass_match u_match_b (
        .ex       (stg[0]),
        .mem      (stg[1]),
        .wb       (stg[2]),
        .rs       (in_RSB),
        .sel      (sel_b),
        .load_use (lu_b)
    );

    // Only a real decoded instruction can be held up by a load in EX.
    assign load_use = in_DVALID && (lu_a || lu_b);

`ifdef SYSCALL_FWD_EN
    // syscall reads $2 (service number) and $4 (argument) implicitly.
    always_comb begin
        out_SYSSEL[0] = stg[0].valid && stg[0].we && (stg[0].dst == RW'(2));
        out_SYSSEL[1] = stg[0].valid && stg[0].we && (stg[0].dst == RW'(4));
        out_SYSSEL[2] = stg[1].valid && stg[1].we && (stg[1].dst == RW'(2));
        out_SYSSEL[3] = stg[1].valid && stg[1].we && (stg[1].dst == RW'(4));
        out_SYSSTALL  = in_DSYS && stg[0].load && (out_SYSSEL[0] || out_SYSSEL[1]);
    end
    assign out_STALL = load_use || out_SYSSTALL;
`else
    assign out_STALL = load_use;
`endif

    assign out_SELA = sel_a;
    assign out_SELB = sel_b;

    // Forwarded data follows the select; zero when the regfile is used.
    always_comb begin
        out_FWDA = '0;
        case (sel_a)
            SEL_EX:  out_FWDA = in_EXRES;
            SEL_MEM: out_FWDA = in_MEMRES;
            SEL_WB:  out_FWDA = in_WBRES;
            default: out_FWDA = '0;
        endcase
    end

    always_comb begin
        out_FWDB = '0;
        case (sel_b)
            SEL_EX:  out_FWDB = in_EXRES;
            SEL_MEM: out_FWDB = in_MEMRES;
            SEL_WB:  out_FWDB = in_WBRES;
            default: out_FWDB = '0;
        endcase
    end

    // At most three writers are tracked, so two bits never overflow.
    always_comb begin
        out_PEND = '0;
        for (int i = 0; i < NSTG; i++) begin
            out_PEND = out_PEND + {1'b0, (stg[i].valid & stg[i].we)};
        end
    end

    // Entries shift one stage per advance. A stalled or flushed decode slot
    // becomes a bubble in EX; the older entries keep moving regardless, which
    // is what lets a load-use stall clear after exactly one cycle.
    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            for (int i = 0; i < NSTG; i++) begin
                stg[i] <= '0;
            end
        end else if (in_EN) begin
            for (int i = 1; i < NSTG; i++) begin
                stg[i] <= stg[i-1];
            end
            if (in_DVALID && !out_STALL && !in_FLUSH) begin
                stg[0] <= '{valid: 1'b1, we: in_DWE, dst: in_DREG, load: in_DLOAD};
            end else begin
                stg[0] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_bypass_tracker.sv
// -----------------------------------------------------------------------------
// tb_wb_bypass_tracker
// Directed bench for wb_bypass_tracker: ALU forwarding through EX/MEM/WB,
// load-use stall, youngest-first priority, register zero, flush during a
// stall, pipeline freeze and synchronous reset.
// -----------------------------------------------------------------------------
module tb_wb_bypass_tracker;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          in_CLK = 1'b0;
    logic          in_RST;
    logic          in_EN;
    logic          in_FLUSH;
    logic          in_DVALID;
    logic          in_DWE;
    logic [RW-1:0] in_DREG;
    logic          in_DLOAD;
    logic [DW-1:0] in_EXRES;
    logic [DW-1:0] in_MEMRES;
    logic [DW-1:0] in_WBRES;
    logic [RW-1:0] in_RSA;
    logic [RW-1:0] in_RSB;
    logic [1:0]    out_SELA;
    logic [1:0]    out_SELB;
    logic [DW-1:0] out_FWDA;
    logic [DW-1:0] out_FWDB;
    logic          out_STALL;
    logic [1:0]    out_PEND;
`ifdef SYSCALL_FWD_EN
    logic          in_DSYS;
    logic [3:0]    out_SYSSEL;
    logic          out_SYSSTALL;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 in_CLK = ~in_CLK;

    wb_bypass_tracker #(.DW(DW), .RW(RW), .NSTG(3)) dut (
        .in_CLK       (in_CLK),
        .in_RST       (in_RST),
        .in_EN        (in_EN),
        .in_FLUSH     (in_FLUSH),
        .in_DVALID    (in_DVALID),
        .in_DWE       (in_DWE),
        .in_DREG      (in_DREG),
        .in_DLOAD     (in_DLOAD),
        .in_EXRES     (in_EXRES),
        .in_MEMRES    (in_MEMRES),
        .in_WBRES     (in_WBRES),
        .in_RSA       (in_RSA),
        .in_RSB       (in_RSB),
`ifdef SYSCALL_FWD_EN
        .in_DSYS      (in_DSYS),
        .out_SYSSEL   (out_SYSSEL),
        .out_SYSSTALL (out_SYSSTALL),
`endif
        .out_SELA     (out_SELA),
        .out_SELB     (out_SELB),
        .out_FWDA     (out_FWDA),
        .out_FWDB     (out_FWDB),
        .out_STALL    (out_STALL),
        .out_PEND     (out_PEND)
    );

    // Advance one clock and move 1 time unit past the edge before anything
    // is driven or sampled.
    task automatic tick();
        @(posedge in_CLK);
        #1;
    endtask

    // Present a decoded instruction to the tracker.
    task automatic applyStimulus(input logic valid, input logic we,
                                 input logic [RW-1:0] dreg, input logic load);
        in_DVALID = valid;
        in_DWE    = we;
        in_DREG   = dreg;
        in_DLOAD  = load;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        in_RST    = 1'b0;
        in_EN     = 1'b1;
        in_FLUSH  = 1'b0;
        in_EXRES  = '0;
        in_MEMRES = '0;
        in_WBRES  = '0;
        in_RSA    = '0;
        in_RSB    = '0;
`ifdef SYSCALL_FWD_EN
        in_DSYS   = 1'b0;
`endif
        applyStimulus(1'b0, 1'b0, '0, 1'b0);

        // Reset state.
        tick();
        tick();
        checkOutput("rst_pend",  32'(out_PEND),  32'd0);
        checkOutput("rst_sela",  32'(out_SELA),  32'd0);
        checkOutput("rst_selb",  32'(out_SELB),  32'd0);
        checkOutput("rst_stall", 32'(out_STALL), 32'd0);
        in_RST = 1'b1;

        // ALU dependency: addu $8, then follow it down the pipe.
        applyStimulus(1'b1, 1'b1, 5'd8, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        in_RSA   = 5'd8;
        in_EXRES = 32'h1234;
        #1;
        checkOutput("alu_ex_sel",   32'(out_SELA),  32'd1);
        checkOutput("alu_ex_fwd",   out_FWDA,       32'h1234);
        checkOutput("alu_ex_stall", 32'(out_STALL), 32'd0);
        checkOutput("alu_ex_pend",  32'(out_PEND),  32'd1);
        tick();
        in_EXRES  = 32'h0;
        in_MEMRES = 32'h1234;
        #1;
        checkOutput("alu_mem_sel", 32'(out_SELA), 32'd2);
        checkOutput("alu_mem_fwd", out_FWDA,      32'h1234);
        tick();
        in_WBRES = 32'h5555;
        #1;
        checkOutput("alu_wb_sel", 32'(out_SELA), 32'd3);
        checkOutput("alu_wb_fwd", out_FWDA,      32'h5555);
        tick();
        checkOutput("drained_pend", 32'(out_PEND), 32'd0);
        checkOutput("drained_sela", 32'(out_SELA), 32'd0);

        // Load-use: lw $9, then an instruction reading $9 on port B.
        in_RSA = 5'd0;
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd11, 1'b0);
        in_RSB = 5'd9;
        #1;
        checkOutput("lu_stall",  32'(out_STALL), 32'd1);
        checkOutput("lu_selb0",  32'(out_SELB),  32'd0);
        checkOutput("lu_fwdb0",  out_FWDB,       32'd0);
        tick();
        in_MEMRES = 32'hCAFE;
        #1;
        checkOutput("lu_stall_gone", 32'(out_STALL), 32'd0);
        checkOutput("lu_selb_mem",   32'(out_SELB),  32'd2);
        checkOutput("lu_fwdb_mem",   out_FWDB,       32'hCAFE);
        tick();
        // EX = $11, MEM = bubble, WB = lw $9.
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        in_RSB = 5'd0;
        #1;
        checkOutput("lu_after_pend", 32'(out_PEND), 32'd2);

        // Priority: $10 in EX and in WB, non-writing instruction in MEM.
        applyStimulus(1'b1, 1'b1, 5'd10, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd10, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        in_RSA   = 5'd10;
        in_EXRES = 32'hAAAA;
        in_WBRES = 32'hBBBB;
        #1;
        checkOutput("prio_sel",  32'(out_SELA), 32'd1);
        checkOutput("prio_fwd",  out_FWDA,      32'hAAAA);
        checkOutput("prio_pend", 32'(out_PEND), 32'd2);

        // Register zero: a write to $0 is tracked but never matches.
        applyStimulus(1'b1, 1'b1, 5'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        in_RSA = 5'd0;
        in_RSB = 5'd10;
        #1;
        checkOutput("r0_sel",   32'(out_SELA), 32'd0);
        checkOutput("r0_fwd",   out_FWDA,      32'd0);
        checkOutput("r0_pend",  32'(out_PEND), 32'd2);
        checkOutput("r0_selb",  32'(out_SELB), 32'd2);
        checkOutput("r0_fwdb",  out_FWDB,      32'hCAFE);

        // Drain, then flush while a load-use stall is pending.
        in_RSB = 5'd0;
        tick();
        tick();
        tick();
        applyStimulus(1'b1, 1'b1, 5'd9, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 5'd12, 1'b0);
        in_RSA   = 5'd9;
        in_FLUSH = 1'b1;
        #1;
        checkOutput("fl_stall_before", 32'(out_STALL), 32'd1);
        tick();
        in_FLUSH = 1'b0;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("fl_pend",  32'(out_PEND),  32'd1);
        checkOutput("fl_sela",  32'(out_SELA),  32'd2);
        checkOutput("fl_stall", 32'(out_STALL), 32'd0);

        // Freeze: a new instruction is offered but nothing may move.
        in_EN = 1'b0;
        applyStimulus(1'b1, 1'b1, 5'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("frz_sela", 32'(out_SELA), 32'd2);
            checkOutput("frz_pend", 32'(out_PEND), 32'd1);
        end

        // Synchronous reset with a live entry.
        in_EN  = 1'b1;
        in_RSB = 5'd9;
        in_RST = 1'b0;
        tick();
        in_RST = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 1'b0);
        #1;
        checkOutput("rst2_pend",  32'(out_PEND),  32'd0);
        checkOutput("rst2_sela",  32'(out_SELA),  32'd0);
        checkOutput("rst2_selb",  32'(out_SELB),  32'd0);
        checkOutput("rst2_stall", 32'(out_STALL), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_bypass_tracker.md
Name: wb_bypass_tracker

Overview:
- Producer side of operand forwarding for the 5-stage MIPS pipeline.
- Records the destination register, write type and result of every in-flight instruction in the EX, MEM and WB stages.
- Answers the two decode-stage source-register queries with a bypass select, the bypassed data and a load-use stall.
- Sits between decode (queries and issue) and the EX/MEM/WB datapath (result inputs).

Parameters:
- DW, 32, datapath width of forwarded results.
- RW, 5, register index width.
- NSTG, 3, tracked stages (EX, MEM, WB); fixed at 3, parameter for documentation only.

Ports:
- in_CLK  input  1  clock; all state updates on posedge.
- in_RST  input  1  synchronous reset, active-low.
- in_EN  input  1  pipeline advance; 0 freezes all tracker state.
- in_FLUSH  input  1  jump/branch taken; kills the instruction entering EX.
- in_DVALID  input  1  decode holds a real instruction (not a bubble or nop word 0).
- in_DWE  input  1  decoded instruction writes a register.
- in_DREG  input  RW  decoded destination (rd for R-type, rt for I-type).
- in_DLOAD  input  1  decoded instruction is lw/lhu (result available only after MEM).
- in_EXRES  input  DW  ALU result of the instruction currently in EX.
- in_MEMRES  input  DW  load data or passed ALU result of the instruction in MEM.
- in_WBRES  input  DW  writeback value of the instruction in WB.
- in_RSA, in_RSB  input  RW  decode-stage source registers.
- out_SELA, out_SELB  output  2  0 = regfile, 1 = EX, 2 = MEM, 3 = WB.
- out_FWDA, out_FWDB  output  DW  selected bypass data; 0 when SEL = 0.
- out_STALL  output  1  load-use hazard; decode must hold.
- out_PEND  output  2  count of valid writing entries (0-3).

Behaviour:
- Stage entries, one each for EX, MEM and WB:
  - fields: valid, we, reg[RW], load.
  - reset (in_RST = 0 at posedge): all valid = 0, all fields = 0, so all outputs = 0.
- Shift on posedge when in_EN = 1:
  - WB <= MEM, MEM <= EX.
  - EX <= decode fields if in_DVALID & ~out_STALL & ~in_FLUSH; otherwise EX <= bubble (valid = 0).
- in_EN = 0: no state change. Outputs remain combinational from the held state.
- Simultaneous events:
  - in_FLUSH with out_STALL: flush wins and a bubble enters EX. Entries already in MEM and WB still shift.
  - Reset mid-operation discards all entries. The first cycle after reset reports SEL = 0, STALL = 0.
- A query on port X matches a stage when:
  - valid & we & reg == in_RSX & in_RSX != 0.
  - Register 0 never matches.
- Priority is youngest first: EX, then MEM, then WB.
- Match in EX:
  - load = 0: SEL = 1, FWD = in_EXRES.
  - load = 1: out_STALL = 1, SEL = 0, FWD = 0 (data not yet available).
- Match in MEM: SEL = 2, FWD = in_MEMRES, for load and non-load alike.
- Match in WB: SEL = 3, FWD = in_WBRES. This covers a regfile without write-before-read.
- out_STALL = OR of the load-use conditions on A and B, gated by in_DVALID. A stall lasts exactly one cycle per load, because the bubble moves the load to MEM.
- Latency: all outputs are combinational from registered entries and the result inputs. Zero-cycle query response; one-cycle tracker update.
- out_PEND = popcount(valid & we) over the three entries; saturation is not possible.

Optional Feature:
- Macro: SYSCALL_FWD_EN.
- With the macro defined:
  - extra input in_DSYS (decoded syscall, instruction word 12).
  - extra output out_SYSSEL[3:0]: bit0/bit1 = EX entry writes $2/$4; bit2/bit3 = MEM entry writes $2/$4.
  - extra output out_SYSSTALL: a load to $2 or $4 in EX while in_DSYS = 1.
  - out_STALL ORs in out_SYSSTALL.
- Without the macro: no extra ports; syscall operands rely on the normal A/B queries.

Decomposition:
- Shared package cpu_pkg:
  - DW and RW constants.
  - stage-entry struct {valid, we, reg, load}.
  - SEL encodings SEL_RF, SEL_EX, SEL_MEM, SEL_WB.
  - opcode constants OP_LW = 6'b100011, OP_LHU = 6'b100101, SYSCALL word = 12.
- Sub-module bypass_match: one combinational lookup per query port, instantiated twice (A and B). Takes the three entries and a source register; returns SEL and a load-use flag.

Test Plan:
- ALU dependency:
  - Stimulus: issue addu $8 (DREG = 8, DWE = 1); next cycle RSA = 8, in_EXRES = 0x1234.
  - Required: SELA = 1, FWDA = 0x1234, STALL = 0.
  - Stimulus: one cycle later, in_MEMRES = 0x1234.
  - Required: SELA = 2.
- Load-use:
  - Stimulus: issue lw $9; next cycle RSB = 9.
  - Required: STALL = 1 for exactly one cycle.
  - Then: SELB = 2, FWDB = in_MEMRES = 0xCAFE.
- Priority:
  - Stimulus: $10 written by both EX and WB entries.
  - Required: SELA = 1, not 3.
- Register zero:
  - Stimulus: destination 0 with DWE = 1; RSA = 0.
  - Required: SELA = 0, FWDA = 0, PEND unchanged by the query.
- Flush with stall:
  - Stimulus: lw $9 in EX, RSA = 9, in_FLUSH = 1.
  - Required: next cycle the EX entry is invalid and PEND = 1 (the load is in MEM).
- Freeze and reset:
  - Stimulus: hold in_EN = 0 for 3 cycles.
  - Required: SEL and PEND stable.
  - Stimulus: then assert in_RST = 0 for one posedge.
  - Required: PEND = 0, all SEL = 0, STALL = 0.
